// File: rtl/rst_conditioner_pkg.sv
// Shared widths and FSM state encoding for the reset conditioner.
package rst_conditioner_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned DcntW  = 20;
    localparam int unsigned CntW   = 16;
    localparam int unsigned EvtW   = 8;

    typedef enum logic [StateW-1:0] {
        StIdle   = 3'd0,
        StWait   = 3'd1,
        StFilter = 3'd2,
        StRun    = 3'd3,
        StHold   = 3'd4
    } state_e;

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchronisers for the reset key and PLL lock, plus key debounce.
module rst_debounce
    import rst_conditioner_pkg::*;
#(
    parameter logic [DcntW-1:0] DEBOUNCE_CYC = 20'd1000000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic key_n_i,
    input  logic pll_locked_i,
    output logic key_db_o,
    output logic lock_s_o
);

    logic             key_meta_q, key_s_q;
    logic             lock_meta_q, lock_s_q;
    logic             key_db_q;
    logic [DcntW-1:0] dcnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            key_meta_q  <= 1'b1;
            key_s_q     <= 1'b1;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            key_meta_q  <= key_n_i;
            key_s_q     <= key_meta_q;
            lock_meta_q <= pll_locked_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // dcnt counts consecutive cycles the synced key disagrees with the accepted level.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            key_db_q <= 1'b1;
            dcnt_q   <= '0;
        end else if (key_s_q == key_db_q) begin
            dcnt_q <= '0;
        end else if (dcnt_q == DEBOUNCE_CYC - 20'd1) begin
            key_db_q <= key_s_q;
            dcnt_q   <= '0;
        end else begin
            dcnt_q <= dcnt_q + 20'd1;
        end
    end

    assign key_db_o = key_db_q;
    assign lock_s_o = lock_s_q;

endmodule

// File: rtl/rst_conditioner.sv
// Combines global reset, debounced key and filtered PLL lock into one registered reset.
module rst_conditioner
    import rst_conditioner_pkg::*;
#(
    parameter logic [DcntW-1:0] DEBOUNCE_CYC    = 20'd1000000,
    parameter logic [CntW-1:0]  LOCK_STABLE_CYC = 16'd4096,
    parameter logic [CntW-1:0]  MIN_ASSERT      = 16'd64
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              key_n_i,
    input  logic              pll_locked_i,
    output logic              rstn_o,
    output logic              lock_lost_o,
    output logic [EvtW-1:0]   evt_cnt_o,
    output logic [StateW-1:0] state_o
);

    logic key_db;
    logic lock_s;
    logic good;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              rstn_q;
    logic              lock_lost_q;
    logic [EvtW-1:0]   evt_cnt_q;

    rst_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .key_n_i      (key_n_i),
        .pll_locked_i (pll_locked_i),
        .key_db_o     (key_db),
        .lock_s_o     (lock_s)
    );

    assign good = lock_s & key_db;

    // rstn_q is updated with the state so it is high exactly while state_q is StRun.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rstn_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            evt_cnt_q   <= '0;
        end else begin
            rstn_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (good) begin
                        state_q <= StFilter;
                        cnt_q   <= '0;
                    end
                end
                StFilter: begin
                    if (!good) begin
                        state_q <= StWait;
                        cnt_q   <= '0;
                    end else if (cnt_q == LOCK_STABLE_CYC - 16'd1) begin
                        state_q <= StRun;
                        rstn_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StRun: begin
                    if (!good) begin
                        state_q <= StHold;
                        cnt_q   <= '0;
                        if (evt_cnt_q != 8'hFF) begin
                            evt_cnt_q <= evt_cnt_q + 8'd1;
                        end
                        if (!lock_s) begin
                            lock_lost_q <= 1'b1;
                        end
                    end else begin
                        rstn_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (cnt_q == MIN_ASSERT - 16'd1) begin
                        state_q <= StWait;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rstn_o      = rstn_q;
    assign lock_lost_o = lock_lost_q;
    assign evt_cnt_o   = evt_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_rst_conditioner.sv
// Directed self-checking bench for rst_conditioner with small timing parameters.
module tb_rst_conditioner;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       key_n_i;
    logic       pll_locked_i;
    logic       rstn_o;
    logic       lock_lost_o;
    logic [7:0] evt_cnt_o;
    logic [2:0] state_o;

    int n_assert = 0;
    int n_fail   = 0;

    rst_conditioner #(
        .DEBOUNCE_CYC    (20'd8),
        .LOCK_STABLE_CYC (16'd16),
        .MIN_ASSERT      (16'd4)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .key_n_i      (key_n_i),
        .pll_locked_i (pll_locked_i),
        .rstn_o       (rstn_o),
        .lock_lost_o  (lock_lost_o),
        .evt_cnt_o    (evt_cnt_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // After this, the next rising edge is edge 1 of the power-up timeline.
    task automatic do_reset();
        rstn_i       = 1'b0;
        pll_locked_i = 1'b0;
        key_n_i      = 1'b1;
        ticks(3);
        rstn_i = 1'b1;
    endtask

    // Lock raised so the first synchroniser flop samples it at edge 10; release at edge 28.
    task automatic power_up(input string tag);
        do_reset();
        ticks(1);
        check({tag, "_wait"}, {5'd0, state_o}, 8'd1);
        ticks(8);
        pll_locked_i = 1'b1;
        ticks(18);
        check({tag, "_e27_rstn"}, {7'd0, rstn_o}, 8'd0);
        check({tag, "_e27_state"}, {5'd0, state_o}, 8'd2);
        ticks(1);
        check({tag, "_e28_rstn"}, {7'd1 & 7'd0, rstn_o}, 8'd1);
        check({tag, "_e28_state"}, {5'd0, state_o}, 8'd3);
    endtask

    initial begin
        rstn_i       = 1'b0;
        key_n_i      = 1'b1;
        pll_locked_i = 1'b0;
        #2;
        check("rst_rstn", {7'd0, rstn_o}, 8'd0);
        check("rst_lost", {7'd0, lock_lost_o}, 8'd0);
        check("rst_evt", evt_cnt_o, 8'd0);
        check("rst_state", {5'd0, state_o}, 8'd0);

        // 1: power-up release
        power_up("pwr");

        // 3: key bounce every 3 cycles never reaches the debounce threshold
        for (int i = 0; i < 10; i++) begin
            key_n_i = (i % 2 == 0) ? 1'b0 : 1'b1;
            ticks(3);
            check("bounce_rstn", {7'd0, rstn_o}, 8'd1);
        end
        ticks(4);
        check("bounce_state", {5'd0, state_o}, 8'd3);
        key_n_i = 1'b0;
        ticks(10);
        check("press_e10_rstn", {7'd0, rstn_o}, 8'd1);
        ticks(1);
        check("press_e11_rstn", {7'd0, rstn_o}, 8'd0);
        check("press_state", {5'd0, state_o}, 8'd4);
        check("press_evt", evt_cnt_o, 8'd1);
        check("press_lost", {7'd0, lock_lost_o}, 8'd0);
        key_n_i = 1'b1;
        ticks(40);
        check("key_rel_rstn", {7'd0, rstn_o}, 8'd1);

        // 4: lock loss in RUN, then minimum low width of 21 cycles
        pll_locked_i = 1'b0;
        ticks(2);
        check("loss_e2_rstn", {7'd0, rstn_o}, 8'd1);
        ticks(1);
        check("loss_e3_rstn", {7'd0, rstn_o}, 8'd0);
        check("loss_lost", {7'd0, lock_lost_o}, 8'd1);
        check("loss_evt", evt_cnt_o, 8'd2);
        pll_locked_i = 1'b1;
        for (int e = 4; e < 24; e++) begin
            ticks(1);
            check("loss_hold_low", {7'd0, rstn_o}, 8'd0);
        end
        ticks(1);
        check("loss_e24_rstn", {7'd0, rstn_o}, 8'd1);

        // 5: async reset mid-RUN clears outputs without a clock edge
        rstn_i = 1'b0;
        #1;
        check("arst_rstn", {7'd0, rstn_o}, 8'd0);
        check("arst_lost", {7'd0, lock_lost_o}, 8'd0);
        check("arst_evt", evt_cnt_o, 8'd0);
        check("arst_state", {5'd0, state_o}, 8'd0);
        power_up("arst");

        // 2: one-cycle lock glitch at FILTER cnt=10 restarts filtering
        do_reset();
        ticks(9);
        pll_locked_i = 1'b1;
        ticks(13);
        check("glitch_state_filt", {5'd0, state_o}, 8'd2);
        pll_locked_i = 1'b0;
        ticks(1);
        pll_locked_i = 1'b1;
        ticks(2);
        check("glitch_state_wait", {5'd0, state_o}, 8'd1);
        ticks(16);
        check("glitch_e41_rstn", {7'd0, rstn_o}, 8'd0);
        ticks(1);
        check("glitch_e42_rstn", {7'd0, rstn_o}, 8'd1);

        // 6: event counter saturates at 255
        for (int i = 1; i <= 300; i++) begin
            pll_locked_i = 1'b0;
            ticks(3);
            check("sat_evt", evt_cnt_o, (i > 255) ? 8'hFF : 8'(i));
            pll_locked_i = 1'b1;
            ticks(22);
        end
        check("sat_state", {5'd0, state_o}, 8'd3);
        check("sat_lost", {7'd0, lock_lost_o}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
